// File: rtl/sgb_icd2_packet_rx.sv
// ICD2 joypad-port receiver: decodes P14/P15 pulses into 16-byte packets, queues them, and drives joy_din back to the GB (1 clk).
// Packets appear on pkt_valid the clk after the stop release; a push into a full queue without a same-cycle pop is dropped and flagged.
module sgb_icd2_packet_rx #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         clk_en,
   input  logic [1:0]   joy_p54,
   output logic [3:0]   joy_din,
   input  logic [31:0]  joypad,
   input  logic [1:0]   mlt_mode,
   output logic [127:0] pkt_data,
   output logic         pkt_valid,
   input  logic         pkt_ready,
   output logic         pkt_overflow,
   output logic         pkt_stop_err,
   input  logic         status_clr,
   output logic [1:0]   player_id
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] C_RST = 2'b00, C_B0 = 2'b10, C_B1 = 2'b01, C_REL = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE, S_RST_REL, S_BIT_WAIT, S_BIT_REL, S_STOP_WAIT, S_STOP_REL
   } state_t;

   state_t         state;
   logic [1:0]     p54_prev;
   logic [7:0]     bitcnt;
   logic [127:0]   sreg;
   logic           line_edge;
   logic           push;
   logic           stop_set;

   assign line_edge = clk_en && (joy_p54 != p54_prev);
   assign push      = line_edge && (state == S_STOP_REL) && (joy_p54 == C_REL);
   assign stop_set  = line_edge && (state == S_STOP_WAIT) && (joy_p54 == C_B1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= S_IDLE;
         p54_prev <= 2'b11;
         bitcnt   <= 8'd0;
         sreg     <= '0;
      end else if (clk_en) begin
         p54_prev <= joy_p54;
         if (joy_p54 != p54_prev) begin
            case (state)
               S_IDLE:      if (joy_p54 == C_RST) state <= S_RST_REL;
               S_RST_REL:   if (joy_p54 == C_REL) begin
                               state  <= S_BIT_WAIT;
                               bitcnt <= 8'd0;
                            end
               S_BIT_WAIT:  if (joy_p54 == C_B0 || joy_p54 == C_B1) begin
                               sreg[bitcnt[6:0]] <= (joy_p54 == C_B1);
                               state             <= S_BIT_REL;
                            end else if (joy_p54 == C_RST) begin
                               state <= S_RST_REL;
                            end
               S_BIT_REL:   if (joy_p54 == C_REL) begin
                               bitcnt <= bitcnt + 8'd1;
                               state  <= (bitcnt == 8'd127) ? S_STOP_WAIT : S_BIT_WAIT;
                            end else if (joy_p54 == C_RST) begin
                               state <= S_RST_REL;
                            end
               S_STOP_WAIT: if (joy_p54 == C_B0)       state <= S_STOP_REL;
                            else if (joy_p54 == C_B1)  state <= S_IDLE;
                            else if (joy_p54 == C_RST) state <= S_RST_REL;
               S_STOP_REL:  if (joy_p54 == C_REL)      state <= S_IDLE;
                            else if (joy_p54 == C_RST) state <= S_RST_REL;
               default:     state <= S_IDLE;
            endcase
         end
      end
   end

   // Packet queue; head is read straight from storage so it holds while stalled.
   logic [127:0] mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, pop, wr_en;

   assign full      = (count == (AW+1)'(FIFO_DEPTH));
   assign pkt_valid = (count != '0);
   assign pop       = pkt_valid && pkt_ready;
   assign wr_en     = push && (!full || pop);
   assign pkt_data  = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         if (wr_en) begin
            mem[wr_ptr] <= sreg;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pkt_overflow <= 1'b0;
         pkt_stop_err <= 1'b0;
      end else if (status_clr) begin
         pkt_overflow <= 1'b0;
         pkt_stop_err <= 1'b0;
      end else begin
         if (push && full && !pop) pkt_overflow <= 1'b1;
         if (stop_set)             pkt_stop_err <= 1'b1;
      end
   end

   // Mode 2 is an unsupported player count and behaves as single-player.
   logic [2:0] plr_cnt;
   always_comb begin
      plr_cnt = 3'd1;
      case (mlt_mode)
         2'd1:    plr_cnt = 3'd2;
         2'd3:    plr_cnt = 3'd4;
         default: plr_cnt = 3'd1;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         player_id <= 2'd0;
      end else if (clk_en) begin
         if ({1'b0, player_id} >= plr_cnt)
            player_id <= 2'd0;
         else if (state == S_IDLE && p54_prev == C_B1 && joy_p54 == C_REL)
            player_id <= ({1'b0, player_id} + 3'd1 >= plr_cnt) ? 2'd0 : player_id + 2'd1;
      end
   end

   logic [7:0] btn;
   logic [3:0] din_nxt;
   assign btn = joypad[{player_id, 3'b000} +: 8];

   always_comb begin
      din_nxt = 4'hF;
      case (joy_p54)
         C_B0:    din_nxt = ~btn[3:0];
         C_B1:    din_nxt = ~btn[7:4];
         C_RST:   din_nxt = ~btn[3:0] & ~btn[7:4];
         default: din_nxt = (mlt_mode != 2'd0) ? 4'hF - {2'b00, player_id} : 4'hF;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) joy_din <= 4'hF;
      else          joy_din <= din_nxt;
   end

endmodule

// File: tb/tb_sgb_icd2_packet_rx.sv
// Directed bench for sgb_icd2_packet_rx: stimulus queues expected packets, a negedge monitor pops and compares on each handshake.
module tb_sgb_icd2_packet_rx;
   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         clk_en = 1'b1;
   logic [1:0]   joy_p54 = 2'b11;
   logic [3:0]   joy_din;
   logic [31:0]  joypad = 32'h0;
   logic [1:0]   mlt_mode = 2'd0;
   logic [127:0] pkt_data;
   logic         pkt_valid;
   logic         pkt_ready = 1'b0;
   logic         pkt_overflow;
   logic         pkt_stop_err;
   logic         status_clr = 1'b0;
   logic [1:0]   player_id;

   int checks = 0;
   int errors = 0;
   logic [127:0] exp_q[$];

   sgb_icd2_packet_rx #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .reset_n(reset_n), .clk_en(clk_en), .joy_p54(joy_p54),
      .joy_din(joy_din), .joypad(joypad), .mlt_mode(mlt_mode),
      .pkt_data(pkt_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_overflow(pkt_overflow), .pkt_stop_err(pkt_stop_err),
      .status_clr(status_clr), .player_id(player_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a handshake seen at negedge pops at the next posedge.
   always @(negedge clk) begin
      if (reset_n && pkt_valid && pkt_ready) begin
         if (exp_q.size() == 0) begin
            chk("pkt_unexpected", pkt_data, 128'h0);
            if (pkt_data == 128'h0) begin
               errors++;
               $display("FAIL pkt_unexpected: got a packet, expected none");
            end
         end else begin
            chk("pkt_data", pkt_data, exp_q.pop_front());
         end
      end
   end

   task automatic settle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic line(input logic [1:0] c);
      @(posedge clk);
      #1 joy_p54 = c;
   endtask

   task automatic send_bit(input logic b);
      line(b ? 2'b01 : 2'b10);
      line(2'b11);
   endtask

   task automatic send_pkt(input logic [127:0] d, input logic stop, input logic expect_push);
      if (expect_push) exp_q.push_back(d);
      line(2'b00);
      line(2'b11);
      for (int i = 0; i < 128; i++) send_bit(d[i]);
      line(stop ? 2'b01 : 2'b10);
      line(2'b11);
      settle(2);
   endtask

   task automatic pop_one();
      pkt_ready = 1'b1;
      settle(1);
      pkt_ready = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain_remaining", 128'(exp_q.size()), 128'h0);
   endtask

   initial begin
      logic [127:0] d;
      logic [3:0] exp_din [4];
      exp_din = '{4'hE, 4'hD, 4'hC, 4'hF};

      // Reset state
      settle(3);
      chk("rst_joy_din", 128'(joy_din), 128'hF);
      chk("rst_pkt_valid", 128'(pkt_valid), 128'h0);
      chk("rst_pkt_data", pkt_data, 128'h0);
      chk("rst_flags", 128'({pkt_overflow, pkt_stop_err}), 128'h0);
      chk("rst_player", 128'(player_id), 128'h0);
      reset_n = 1'b1;
      settle(2);

      // 1: bytes 0x00..0x0F, good stop
      for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(i);
      exp_q.push_back(128'h0F0E0D0C0B0A09080706050403020100);
      send_pkt(d, 1'b0, 1'b0);
      chk("t1_valid", 128'(pkt_valid), 128'h1);
      chk("t1_flags", 128'({pkt_overflow, pkt_stop_err}), 128'h0);
      pop_one();
      drain();
      chk("t1_empty", 128'(pkt_valid), 128'h0);

      // 2: bad stop bit
      send_pkt({16{8'h3C}}, 1'b1, 1'b0);
      chk("t2_valid", 128'(pkt_valid), 128'h0);
      chk("t2_stop_err", 128'(pkt_stop_err), 128'h1);
      status_clr = 1'b1;
      settle(1);
      status_clr = 1'b0;
      chk("t2_stop_clr", 128'(pkt_stop_err), 128'h0);

      // 3: restart after 40 bits, then full 0xA5 packet
      line(2'b00);
      line(2'b11);
      for (int i = 0; i < 40; i++) send_bit(i[0]);
      send_pkt({16{8'hA5}}, 1'b0, 1'b1);
      chk("t3_valid", 128'(pkt_valid), 128'h1);
      pop_one();
      chk("t3_one_entry", 128'(pkt_valid), 128'h0);
      chk("t3_drained", 128'(exp_q.size()), 128'h0);

      // 4: overflow with 5 packets, ready low
      for (int k = 0; k < 5; k++) send_pkt({16{8'(8'h10 + k)}}, 1'b0, k < 4);
      chk("t4_overflow", 128'(pkt_overflow), 128'h1);
      chk("t4_head_stable", pkt_data, {16{8'h10}});
      pkt_ready = 1'b1;
      drain();
      settle(2);
      chk("t4_empty", 128'(pkt_valid), 128'h0);
      status_clr = 1'b1;
      settle(1);
      status_clr = 1'b0;
      chk("t4_ovf_clr", 128'(pkt_overflow), 128'h0);

      // 5: 4-player rotation
      mlt_mode = 2'd3;
      settle(2);
      chk("t5_din_p0", 128'(joy_din), 128'hF);
      for (int k = 0; k < 4; k++) begin
         line(2'b01);
         line(2'b11);
         settle(2);
         chk("t5_din_rot", 128'(joy_din), 128'(exp_din[k]));
      end
      line(2'b01);
      line(2'b11);
      settle(2);
      chk("t5_player1", 128'(player_id), 128'h1);
      clk_en = 1'b0;
      line(2'b01);
      line(2'b11);
      settle(1);
      clk_en = 1'b1;
      settle(2);
      chk("t5_clk_en_hold", 128'(player_id), 128'h1);
      send_pkt({16{8'hFF}}, 1'b0, 1'b1);
      chk("t5_pkt_no_rot", 128'(player_id), 128'h1);
      chk("t5_din_p1", 128'(joy_din), 128'hE);
      drain();
      mlt_mode = 2'd0;
      settle(2);
      chk("t5_force0", 128'(player_id), 128'h0);

      // 6: joypad nibbles, then reset mid-packet with a queued entry
      pkt_ready = 1'b0;
      send_pkt({16{8'hD6}}, 1'b0, 1'b1);
      joypad = 32'h0000_0081;
      line(2'b10);
      settle(1);
      chk("t6_din_dir", 128'(joy_din), 128'hE);
      line(2'b01);
      settle(1);
      chk("t6_din_btn", 128'(joy_din), 128'h7);
      line(2'b00);
      settle(1);
      chk("t6_din_and", 128'(joy_din), 128'h6);
      line(2'b11);
      settle(1);
      chk("t6_din_rel", 128'(joy_din), 128'hF);
      for (int i = 0; i < 20; i++) send_bit(1'b1);
      reset_n = 1'b0;
      exp_q.delete();
      settle(2);
      chk("t6_rst_valid", 128'(pkt_valid), 128'h0);
      chk("t6_rst_din", 128'(joy_din), 128'hF);
      reset_n = 1'b1;
      settle(2);
      pkt_ready = 1'b1;
      send_pkt(128'h0123456789ABCDEF_FEDCBA9876543210, 1'b0, 1'b1);
      drain();
      chk("t6_final_empty", 128'(pkt_valid), 128'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
